// File: rtl/i2s_receiver.sv
// I2S deserializer: oversamples sck/ws/sdo in the clk domain, locks to the frame and
// returns 24-bit left/right sample pairs with a valid strobe and a slot-length error flag.
//
// state | meaning
// SYNC  | unlocked, waiting for a ws falling edge to start a left slot
// LEFT  | receiving the left (audio0) slot
// RIGHT | receiving the right (audio1) slot
module i2s_receiver #(
  parameter int DATA_BITS = 24,
  parameter int SLOT_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en_in,
  input  logic                 sck_in,
  input  logic                 ws_in,
  input  logic                 sdo_in,
  output logic [DATA_BITS-1:0] audio0_out,
  output logic [DATA_BITS-1:0] audio1_out,
  output logic                 valid_out,
  output logic                 frame_err_out,
  output logic                 locked_out
);

  typedef enum logic [1:0] {SYNC, LEFT, RIGHT} state_t;

  localparam logic [5:0] CNT_LAST = 6'(SLOT_BITS - 1);
  localparam logic [5:0] DATA_LIM = 6'(DATA_BITS);

  state_t               state;
  logic                 sck_m, sck_s, sck_d;
  logic                 ws_m, ws_s, sdo_m, sdo_s;
  logic                 ws_last;
  logic [5:0]           cnt;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] left_hold;
  logic                 rise, chg, cnt_last, shift_en;

  // Equal-depth synchronizers keep the three lines aligned to each other.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_m <= 1'b0;
      sck_s <= 1'b0;
      sck_d <= 1'b0;
      ws_m  <= 1'b0;
      ws_s  <= 1'b0;
      sdo_m <= 1'b0;
      sdo_s <= 1'b0;
    end else begin
      sck_m <= sck_in;
      sck_s <= sck_m;
      sck_d <= sck_s;
      ws_m  <= ws_in;
      ws_s  <= ws_m;
      sdo_m <= sdo_in;
      sdo_s <= sdo_m;
    end
  end

  assign rise     = sck_s & ~sck_d;
  assign chg      = ws_s ^ ws_last;
  assign cnt_last = (cnt == CNT_LAST);
  assign shift_en = (cnt < DATA_LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= SYNC;
      cnt           <= '0;
      ws_last       <= 1'b0;
      shreg         <= '0;
      left_hold     <= '0;
      audio0_out    <= '0;
      audio1_out    <= '0;
      valid_out     <= 1'b0;
      frame_err_out <= 1'b0;
      locked_out    <= 1'b0;
    end else begin
      valid_out     <= 1'b0;
      frame_err_out <= 1'b0;
      if (rise) ws_last <= ws_s;
      if (!en_in) begin
        state      <= SYNC;
        locked_out <= 1'b0;
      end else if (rise) begin
        case (state)
          SYNC: begin
            if (ws_last && !ws_s) begin
              state      <= LEFT;
              locked_out <= 1'b1;
              cnt        <= '0;
              shreg      <= '0;
            end else if (chg) begin
              cnt <= '0;
            end else begin
              cnt <= cnt + 6'd1;
            end
          end
          LEFT, RIGHT: begin
            if (chg) begin
              cnt <= '0;
              if (!cnt_last) begin
                // Short slot: drop the pending pair; re-lock waits for the next ws fall.
                state         <= SYNC;
                locked_out    <= 1'b0;
                frame_err_out <= 1'b1;
              end else if (state == LEFT) begin
                left_hold <= shreg;
                state     <= RIGHT;
              end else begin
                audio0_out <= left_hold;
                audio1_out <= shreg;
                valid_out  <= 1'b1;
                state      <= LEFT;
              end
            end else if (cnt_last) begin
              state         <= SYNC;
              locked_out    <= 1'b0;
              frame_err_out <= 1'b1;
              cnt           <= cnt + 6'd1;
            end else begin
              cnt <= cnt + 6'd1;
              if (shift_en) shreg <= {shreg[DATA_BITS-2:0], sdo_s};
            end
          end
          default: begin
            state      <= SYNC;
            locked_out <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2s_receiver.sv
// Scoreboard bench for i2s_receiver: directed I2S frames at sck = clk/8, expected
// sample pairs queued by the stimulus and matched by an independent monitor.
module tb_i2s_receiver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en_in = 1'b0;
  logic        sck_in = 1'b0;
  logic        ws_in = 1'b0;
  logic        sdo_in = 1'b0;
  logic [23:0] audio0_out, audio1_out;
  logic        valid_out, frame_err_out, locked_out;

  int checks = 0;
  int failures = 0;
  int valid_seen = 0;
  int err_seen = 0;
  logic [47:0] exp_q[$];

  i2s_receiver #(.DATA_BITS(24), .SLOT_BITS(32)) dut (
    .clk(clk), .rst_n(rst_n), .en_in(en_in), .sck_in(sck_in), .ws_in(ws_in),
    .sdo_in(sdo_in), .audio0_out(audio0_out), .audio1_out(audio1_out),
    .valid_out(valid_out), .frame_err_out(frame_err_out), .locked_out(locked_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One sck period: ws/sdo change with the falling edge, 4 clk low then 4 clk high.
  task automatic send_bit(input logic w, input logic d);
    sck_in = 1'b0;
    ws_in  = w;
    sdo_in = d;
    repeat (4) @(negedge clk);
    sck_in = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // I2S slot: bit 0 is the ws-change bit, bits 1..24 carry data MSB first, rest padding.
  task automatic send_slot(input logic w, input logic [23:0] data, input logic pad,
                           input int nbits);
    for (int k = 0; k < nbits; k++) begin
      if (k >= 1 && k <= 24) send_bit(w, data[24-k]);
      else send_bit(w, pad);
    end
  endtask

  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (valid_out) begin
      valid_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid: got %h/%h expected no valid", audio0_out, audio1_out);
      end else begin
        chk("sample_pair", {audio0_out, audio1_out}, exp_q.pop_front());
      end
      if (prev_valid) chk("valid_one_cycle", 48'(prev_valid), 48'd0);
    end
    if (frame_err_out) err_seen++;
    prev_valid = valid_out;
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_audio0", 48'(audio0_out), 48'd0);
    chk("rst_audio1", 48'(audio1_out), 48'd0);
    chk("rst_valid", 48'(valid_out), 48'd0);
    chk("rst_err", 48'(frame_err_out), 48'd0);
    chk("rst_locked", 48'(locked_out), 48'd0);
    rst_n = 1'b1;
    en_in = 1'b1;
    repeat (2) @(negedge clk);

    // Dummy frame, then lock at the ws fall and decode.
    send_slot(1'b0, 24'h0, 1'b0, 32);
    send_slot(1'b1, 24'h0, 1'b0, 32);
    chk("no_lock_dummy", 48'(locked_out), 48'd0);
    send_slot(1'b0, 24'h800001, 1'b0, 32);
    chk("locked_left", 48'(locked_out), 48'd1);
    exp_q.push_back({24'h800001, 24'h7FFFFF});
    send_slot(1'b1, 24'h7FFFFF, 1'b0, 32);

    // Padding all ones must be ignored.
    exp_q.push_back({24'h123456, 24'hABCDEF});
    send_slot(1'b0, 24'h123456, 1'b1, 32);
    chk("valid_count_1", 48'(valid_seen), 48'd1);
    send_slot(1'b1, 24'hABCDEF, 1'b1, 32);

    // Short right slot (31 rises): error, unlock, outputs hold.
    send_slot(1'b0, 24'h111111, 1'b0, 32);
    chk("valid_count_2", 48'(valid_seen), 48'd2);
    send_slot(1'b1, 24'h222222, 1'b0, 31);
    send_slot(1'b0, 24'h333333, 1'b0, 32);
    chk("short_err", 48'(err_seen), 48'd1);
    chk("short_unlocked", 48'(locked_out), 48'd0);
    chk("short_hold", {audio0_out, audio1_out}, {24'h123456, 24'hABCDEF});
    send_slot(1'b1, 24'h444444, 1'b0, 32);
    chk("no_relock_yet", 48'(locked_out), 48'd0);
    send_slot(1'b0, 24'h555555, 1'b0, 32);
    chk("relocked", 48'(locked_out), 48'd1);
    exp_q.push_back({24'h555555, 24'h666666});
    send_slot(1'b1, 24'h666666, 1'b0, 32);

    // Long left slot: error on the 33rd rise.
    send_slot(1'b0, 24'h0, 1'b0, 32);
    chk("valid_count_3", 48'(valid_seen), 48'd3);
    chk("long_no_err_32", 48'(err_seen), 48'd1);
    chk("long_locked_32", 48'(locked_out), 48'd1);
    send_bit(1'b0, 1'b0);
    chk("long_err_33", 48'(err_seen), 48'd2);
    chk("long_unlocked", 48'(locked_out), 48'd0);

    // Enable drop mid-slot.
    send_slot(1'b1, 24'h0, 1'b0, 32);
    send_slot(1'b0, 24'h777777, 1'b0, 32);
    chk("en_locked", 48'(locked_out), 48'd1);
    send_slot(1'b1, 24'h888888, 1'b0, 10);
    en_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("en_unlocked", 48'(locked_out), 48'd0);
    send_slot(1'b1, 24'h0, 1'b0, 22);
    chk("en_no_err", 48'(err_seen), 48'd2);
    en_in = 1'b1;
    send_slot(1'b0, 24'hAAAAAA, 1'b0, 32);
    chk("en_relocked", 48'(locked_out), 48'd1);
    exp_q.push_back({24'hAAAAAA, 24'hBBBBBB});
    send_slot(1'b1, 24'hBBBBBB, 1'b0, 32);

    // Reset during bit 10 of the right slot.
    send_slot(1'b0, 24'hCCCCCC, 1'b0, 32);
    chk("valid_count_4", 48'(valid_seen), 48'd4);
    send_slot(1'b1, 24'hDDDDDD, 1'b0, 10);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_audio", {audio0_out, audio1_out}, 48'd0);
    chk("mid_rst_locked", 48'(locked_out), 48'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_slot(1'b1, 24'h0, 1'b0, 22);
    send_slot(1'b0, 24'h121212, 1'b0, 32);
    exp_q.push_back({24'h121212, 24'h343434});
    send_slot(1'b1, 24'h343434, 1'b0, 32);
    chk("no_valid_before_full", 48'(valid_seen), 48'd4);
    send_slot(1'b0, 24'h0, 1'b0, 4);
    repeat (10) @(negedge clk);

    chk("final_valid_count", 48'(valid_seen), 48'd5);
    chk("final_err_count", 48'(err_seen), 48'd2);
    chk("queue_drained", 48'(exp_q.size()), 48'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
